mux_4to1_rr_arb: RTL and testbench

//  4-to-1 merge: four valid/ready source channels into one output stream.
//  - Round-robin arbitration with packet lock (in_last).
//  - Registered output, 1-deep output buffer.
//  - out_sel reports the source channel, with the same encoding as the demux s select.
//  - Sits upstream of a DEMUX_1TO4-style fan-out, or collects its four outputs back onto one bus.

---
 rtl/mux_4to1_rr_arb.sv | 146 ++++++++++++++
 tb/tb_mux_4to1_rr_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_4to1_rr_arb.sv
// mux_4to1_rr_arb
//   Merges four valid/ready source channels onto one registered output
//   stream. Sources are served round-robin; once a channel's packet is
//   started (beat with in_last=0) the arbiter stays on that channel until
//   its last beat. The output stage is a single registered beat that can be
//   refilled in the same cycle it drains.
//
// Ports
//   clk        single clock, all state updates on posedge
//   rst        synchronous, active-high reset
//   in_data    4*WIDTH  channel k data at in_data[k*WIDTH +: WIDTH]
//   in_valid   4        channel k presents a beat
//   in_last    4        channel k beat ends its packet
//   in_ready   4        one-hot accept strobe (valid & ready handshake)
//   out_data   WIDTH    registered beat data
//   out_sel    2        source channel of out_data
//   out_last   1        registered last flag
//   out_valid  1        output register holds a beat
//   out_ready  1        sink takes the beat when out_valid & out_ready
module mux_4to1_rr_arb #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [4*WIDTH-1:0] in_data,
   input  logic [3:0]         in_valid,
   input  logic [3:0]         in_last,
   output logic [3:0]         in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [1:0]         out_sel,
   output logic               out_last,
   output logic               out_valid,
   input  logic               out_ready
);

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] ptr, ptr_nxt;
   logic [1:0] lock_ch, lock_ch_nxt;

   logic             load;
   logic             gnt_any;
   logic [1:0]       gnt;
   logic [2:0]       rr_res;
   logic [WIDTH-1:0] ch_data [4];

   logic [WIDTH-1:0] data_p0;
   logic [1:0]       sel_p0;
   logic             last_p0;
   logic             vld_p0;

   // Returns {found, channel}: first requester scanning start, start+1, ...
   // with 2-bit wraparound. The loop runs from the farthest offset down so
   // the nearest requester is the one left in pick.
   function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                          input logic [1:0] start);
      logic [2:0] pick;
      logic [1:0] c;
      pick = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         c = start + 2'(i);
         if (req[c]) pick = {1'b1, c};
      end
      return pick;
   endfunction

   always_comb begin
      for (int k = 0; k < 4; k++) ch_data[k] = in_data[k*WIDTH +: WIDTH];
   end

   // Arbitration and next-state. Grant only when the output register can
   // take a beat this cycle; in_ready never feeds back into itself.
   always_comb begin
      load        = ~vld_p0 | out_ready;
      rr_res      = rr_pick(in_valid, ptr);
      gnt_any     = 1'b0;
      gnt         = 2'd0;
      state_nxt   = state;
      ptr_nxt     = ptr;
      lock_ch_nxt = lock_ch;

      if (!rst && load) begin
         if (state == LOCKED) begin
            if (in_valid[lock_ch]) begin
               gnt_any = 1'b1;
               gnt     = lock_ch;
            end
         end else if (rr_res[2]) begin
            gnt_any = 1'b1;
            gnt     = rr_res[1:0];
         end
      end

      if (gnt_any) begin
         if (in_last[gnt]) begin
            state_nxt = UNLOCKED;
            ptr_nxt   = gnt + 2'd1;
         end else begin
            state_nxt   = LOCKED;
            lock_ch_nxt = gnt;
         end
      end

      in_ready = gnt_any ? (4'b0001 << gnt) : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= UNLOCKED;
         ptr     <= 2'd0;
         lock_ch <= 2'd0;
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         lock_ch <= lock_ch_nxt;
      end
   end

   // ---- stage p0: output register (accept -> out_valid in one cycle) ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0  <= 1'b0;
         data_p0 <= '0;
         sel_p0  <= 2'd0;
         last_p0 <= 1'b0;
      end else if (gnt_any) begin
         vld_p0  <= 1'b1;
         data_p0 <= ch_data[gnt];
         sel_p0  <= gnt;
         last_p0 <= in_last[gnt];
      end else if (load) begin
         // Drained with nothing to refill: payload holds, only valid drops.
         vld_p0 <= 1'b0;
      end
   end

   assign out_data  = data_p0;
   assign out_sel   = sel_p0;
   assign out_last  = last_p0;
   assign out_valid = vld_p0;

endmodule

// File: tb/tb_mux_4to1_rr_arb.sv
// tb_mux_4to1_rr_arb
//   Directed scenarios followed by randomized traffic for mux_4to1_rr_arb.
//   A behavioural model (round-robin pointer, packet-lock owner, one-beat
//   output buffer) predicts in_ready each cycle and the registered outputs
//   after each clock edge.
module tb_mux_4to1_rr_arb;

   localparam int WIDTH = 8;

   logic               clk;
   logic               rst;
   logic [4*WIDTH-1:0] in_data;
   logic [3:0]         in_valid;
   logic [3:0]         in_last;
   logic [3:0]         in_ready;
   logic [WIDTH-1:0]   out_data;
   logic [1:0]         out_sel;
   logic               out_last;
   logic               out_valid;
   logic               out_ready;

   mux_4to1_rr_arb #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // behavioural model state
   int         m_ptr     = 0;
   bit         m_lock    = 0;
   int         m_lock_ch = 0;
   bit         m_vld     = 0;
   logic [7:0] m_data    = 8'h00;
   int         m_sel     = 0;
   bit         m_last    = 0;
   int         pend_g    = -1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Channel granted this cycle, or -1.
   function automatic int model_grant();
      if (rst) return -1;
      if (m_vld && !out_ready) return -1;
      if (m_lock) return in_valid[m_lock_ch] ? m_lock_ch : -1;
      for (int k = 0; k < 4; k++) begin
         if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
      end
      return -1;
   endfunction

   function automatic void model_update(input int g);
      if (rst) begin
         m_ptr = 0; m_lock = 0; m_lock_ch = 0;
         m_vld = 0; m_data = 8'h00; m_sel = 0; m_last = 0;
      end else if (g >= 0) begin
         m_vld  = 1;
         m_data = in_data[g*WIDTH +: WIDTH];
         m_sel  = g;
         m_last = in_last[g];
         if (in_last[g]) begin
            m_lock = 0;
            m_ptr  = (g + 1) % 4;
         end else begin
            m_lock    = 1;
            m_lock_ch = g;
         end
      end else if (!m_vld || out_ready) begin
         m_vld = 0;
      end
   endfunction

   // Mid-cycle: predict and check the combinational accept strobe.
   task automatic half_a();
      #4;
      pend_g = model_grant();
      chk("in_ready", {28'd0, in_ready}, (pend_g >= 0) ? (32'd1 << pend_g) : 32'd0);
   endtask

   // Clock edge, model update, then registered outputs just after the edge.
   task automatic half_b();
      @(posedge clk);
      model_update(pend_g);
      #1;
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
      chk("out_data",  {24'd0, out_data},  {24'd0, m_data});
      chk("out_sel",   {30'd0, out_sel},   m_sel);
      chk("out_last",  {31'd0, out_last},  {31'd0, m_last});
   endtask

   task automatic step();
      half_a();
      half_b();
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 4'b0000; in_last = 4'b0000; out_ready = 1'b1;
      step();
      rst = 1'b0;
   endtask

   int exp_seq3 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   int exp_seq4 [5] = '{1, 1, 1, 3, 0};

   initial begin
      rst = 1'b1; in_data = '0; in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;

      // 1. reset held two cycles with every channel requesting
      for (int c = 0; c < 2; c++) begin
         half_a();
         chk("rst_in_ready", {28'd0, in_ready}, 32'h0);
         half_b();
         chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
         chk("rst_out_sel", {30'd0, out_sel}, 32'h0);
      end
      rst = 1'b0;

      // 2. single beat from ch2
      in_valid = 4'b0100; in_last = 4'b0100; in_data = 32'h00A5_0000; out_ready = 1'b1;
      half_a();
      chk("t2_in_ready", {28'd0, in_ready}, 32'h4);
      half_b();
      chk("t2_out_valid", {31'd0, out_valid}, 32'h1);
      chk("t2_out_data", {24'd0, out_data}, 32'hA5);
      chk("t2_out_sel", {30'd0, out_sel}, 32'h2);

      // 3. round robin over four always-valid single-beat sources
      do_reset();
      in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         in_data = $urandom;
         half_a();
         chk("t3_onehot", $countones(in_ready), 32'd1);
         half_b();
         chk("t3_out_sel", {30'd0, out_sel}, exp_seq3[c]);
      end

      // 4. packet lock on ch1 while ch0 and ch3 wait
      do_reset();
      in_valid = 4'b0001; in_last = 4'b0001; in_data = 32'h0000_0010;
      step();                                   // ch0 beat moves ptr to 1
      for (int c = 0; c < 5; c++) begin
         in_data = 32'h3000_2000 | (32'(c) << 8) | 32'h0000_0040;
         case (c)
            0, 1:    begin in_valid = 4'b1011; in_last = 4'b1001; end
            2:       begin in_valid = 4'b1011; in_last = 4'b1011; end
            3:       begin in_valid = 4'b1001; in_last = 4'b1001; end
            default: begin in_valid = 4'b0001; in_last = 4'b0001; end
         endcase
         step();
         chk("t4_out_sel", {30'd0, out_sel}, exp_seq4[c]);
      end

      // 5. backpressure holds the buffered beat and blocks all inputs
      do_reset();
      in_valid = 4'b0001; in_last = 4'b0001; in_data = 32'h0000_003C; out_ready = 1'b1;
      step();
      out_ready = 1'b0; in_valid = 4'b1111; in_last = 4'b1111; in_data = 32'h1122_3344;
      for (int c = 0; c < 5; c++) begin
         half_a();
         chk("t5_in_ready", {28'd0, in_ready}, 32'h0);
         half_b();
         chk("t5_hold_data", {24'd0, out_data}, 32'h3C);
         chk("t5_hold_valid", {31'd0, out_valid}, 32'h1);
      end
      out_ready = 1'b1;
      half_a();
      chk("t5_release", {28'd0, in_ready}, 32'h2);
      half_b();
      chk("t5_next_data", {24'd0, out_data}, 32'h33);
      chk("t5_next_sel", {30'd0, out_sel}, 32'h1);

      // 6. reset in the middle of a ch2 packet clears the lock
      do_reset();
      in_valid = 4'b0100; in_last = 4'b0000; in_data = 32'h00C1_0000;
      step();
      in_data = 32'h00C2_0000;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      in_valid = 4'b0101; in_last = 4'b0101; in_data = 32'h0077_0055;
      half_a();
      chk("t6_in_ready", {28'd0, in_ready}, 32'h1);
      half_b();
      chk("t6_out_sel", {30'd0, out_sel}, 32'h0);
      chk("t6_out_data", {24'd0, out_data}, 32'h55);

      // randomized traffic with occasional resets and sink stalls
      for (int c = 0; c < 600; c++) begin
         rst       = ($urandom_range(0, 79) == 0);
         in_valid  = 4'($urandom);
         in_last   = 4'($urandom | $urandom);
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
